program_sequencer_stack: RTL

Parametrised next-generation program sequencer for the CME341 microprocessor.
- Generates the program-memory address every cycle.
- Adds a subroutine call/return stack, a hold (stall) input and configurable widths.
- Keeps the existing skip (NOPC8-style pc+2), jmp and jmp_nz/dont_jmp semantics.
- Sits between instruction decoder and program memory; from_PS feeds the data-path source mux.

---
 rtl/program_sequencer_stack.sv | 122 ++++++++++++
 1 files changed

// File: rtl/program_sequencer_stack.sv
`default_nettype none
// ============================================================================
// Module      : program_sequencer_stack
// Description : Program sequencer that produces the next program-memory
//               address. Supports skip, jmp and jmp_nz, plus call/ret through
//               a LIFO return stack and a hold (stall) input.
// Revision    : 1.0 - initial release
// ============================================================================
module program_sequencer_stack #(
    parameter int PC_W        = 8,
    parameter int JA_W        = 4,
    parameter int STACK_DEPTH = 4,
    parameter int SP_W        = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sync_reset,
    input  logic            hold,
    input  logic            skip,
    input  logic            jmp,
    input  logic            jmp_nz,
    input  logic            dont_jmp,
    input  logic            call,
    input  logic            ret,
    input  logic [JA_W-1:0] jmp_addr,
    output logic [PC_W-1:0] pm_addr,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] from_PS,
    output logic [SP_W-1:0] stack_count,
    output logic            stack_err
);

    logic [PC_W-1:0] tgt;
    logic [PC_W-1:0] pc_inc1;
    logic [PC_W-1:0] pc_inc2;
    logic [PC_W-1:0] top_entry;
    logic [PC_W-1:0] stack_mem [STACK_DEPTH];
    logic            stack_full;
    logic            stack_empty;
    logic            do_push;
    logic            do_pop;
    logic            set_err;

    generate
        if (JA_W == PC_W) begin : g_tgt_full
            assign tgt = jmp_addr;
        end else begin : g_tgt_pad
            assign tgt = {jmp_addr, {(PC_W-JA_W){1'b0}}};
        end
    endgenerate

    assign pc_inc1     = pc + PC_W'(1);
    assign pc_inc2     = pc + PC_W'(2);
    assign stack_full  = (stack_count == SP_W'(STACK_DEPTH));
    assign stack_empty = (stack_count == '0);
    assign from_PS     = top_entry;

    // Top-of-stack select; no entry matches when empty, so the result is 0.
    always_comb begin
        top_entry = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (stack_count == SP_W'(i + 1)) top_entry = stack_mem[i];
        end
    end

    always_comb begin
        pm_addr = pc_inc1;
        do_push = 1'b0;
        do_pop  = 1'b0;
        set_err = 1'b0;
        if (!reset_n) begin
            pm_addr = '0;
        end else if (sync_reset) begin
            pm_addr = '0;
        end else if (hold) begin
            pm_addr = pc;
        end else if (skip) begin
            pm_addr = pc_inc2;
        end else if (jmp) begin
            pm_addr = tgt;
        end else if (call) begin
            pm_addr = tgt;
            if (stack_full) set_err = 1'b1;
            else            do_push = 1'b1;
        end else if (ret) begin
            if (stack_empty) begin
                pm_addr = pc_inc1;
                set_err = 1'b1;
            end else begin
                pm_addr = top_entry;
                do_pop  = 1'b1;
            end
        end else if (jmp_nz && !dont_jmp) begin
            pm_addr = tgt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= '0;
            stack_count <= '0;
            stack_err   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_mem[i] <= '0;
        end else begin
            pc <= pm_addr;
            if (sync_reset) begin
                stack_count <= '0;
            end else if (do_push) begin
                stack_count <= stack_count + SP_W'(1);
            end else if (do_pop) begin
                stack_count <= stack_count - SP_W'(1);
            end
            // The new entry lands at index stack_count, becoming the new top.
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (do_push && stack_count == SP_W'(i)) stack_mem[i] <= pc_inc1;
            end
            if (set_err) stack_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire
